// File: rtl/seq_detector_param.sv
// Serial pattern detector with a run-time loadable pattern, length and overlap mode.
// Optional saturating match counter is built only when SEQ_DET_MATCH_CNT_EN is defined.
module seq_detector_param #(
    parameter int                 MAX_LEN     = 8,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(8'b0000_0110),
    parameter int                 DEF_LEN     = 4,
    parameter int                 CNT_W       = 8,
    localparam int                LEN_W       = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               x,
    input  logic               x_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               z,
    output logic               cfg_err,
    output logic [CNT_W-1:0]   match_cnt
);

    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               overlap_q, overlap_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               cfg_err_q, cfg_err_d;

    logic [MAX_LEN-1:0] window_s;
    logic [MAX_LEN-1:0] mask_s;
    logic               accept_s;
    logic               fill_ok_s;
    logic               z_s;
    logic               cfg_ok_s;
    logic               unused_hist_msb_s;

    assign window_s          = {hist_q[MAX_LEN-2:0], x};
    assign accept_s          = x_valid & ~cfg_load & ~rst;
    assign cfg_ok_s          = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    assign unused_hist_msb_s = hist_q[MAX_LEN-1];

    // State register: configuration, history, fill level and error pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            pattern_q <= DEF_PATTERN;
            len_q     <= LEN_W'(DEF_LEN);
            overlap_q <= 1'b1;
            hist_q    <= '0;
            fill_q    <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // Next state: a load (valid or not) always wins over the data bit in the same cycle
    always_comb begin
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        cfg_err_d = cfg_load & ~cfg_ok_s;
        if (cfg_load) begin
            if (cfg_ok_s) begin
                pattern_d = cfg_pattern;
                len_d     = cfg_len;
                overlap_d = cfg_overlap;
                fill_d    = '0;
            end else begin
                fill_d    = fill_q;
            end
        end else if (accept_s) begin
            hist_d = window_s;
            if (z_s && !overlap_q) begin
                fill_d = '0;
            end else if (fill_q != LEN_W'(MAX_LEN)) begin
                fill_d = fill_q + LEN_W'(1);
            end else begin
                fill_d = fill_q;
            end
        end else begin
            hist_d = hist_q;
        end
    end

    // Output: Mealy match on the window that includes the bit arriving this cycle
    always_comb begin
        mask_s = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask_s[i] = (i < int'(len_q));
        end
        fill_ok_s = ((LEN_W+1)'(fill_q) + (LEN_W+1)'(1)) >= (LEN_W+1)'(len_q);
        z_s       = accept_s & fill_ok_s & (((window_s ^ pattern_q) & mask_s) == '0);
    end

    assign z       = z_s;
    assign cfg_err = cfg_err_q;

`ifdef SEQ_DET_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter next state: clear beats increment, increment saturates
    always_comb begin
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (z_s && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_cnt = cnt_q;
`else
    logic unused_cnt_clr_s;

    assign unused_cnt_clr_s = cnt_clr;
    assign match_cnt        = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: queue-based reference model checked every cycle plus directed literal checks.
module tb_seq_detector_param;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = 3;
`ifdef SEQ_DET_MATCH_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic               clk;
    logic               rst;
    logic               x;
    logic               x_valid;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               cnt_clr;
    logic               z;
    logic               cfg_err;
    logic [CNT_W-1:0]   match_cnt;

    int checks = 0;
    int errors = 0;

    seq_detector_param #(
        .MAX_LEN(MAX_LEN),
        .DEF_PATTERN(8'b0000_0110),
        .DEF_LEN(4),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .x(x),
        .x_valid(x_valid),
        .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap),
        .cnt_clr(cnt_clr),
        .z(z),
        .cfg_err(cfg_err),
        .match_cnt(match_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int cnt_exp(input int n);
        return CNT_EN ? ((n > CNT_MAX) ? CNT_MAX : n) : 0;
    endfunction

    // Reference model: list of bits received since the last clear, newest at the back
    bit         mq[$];
    bit         w[$];
    logic [7:0] m_pat   = 8'b0000_0110;
    int         m_len   = 4;
    bit         m_ovl   = 1'b1;
    bit         m_err   = 1'b0;
    int         m_cnt   = 0;
    bit         m_valid = 1'b0;
    bit         m_acc;
    bit         m_hit;

    always @(negedge clk) begin
        m_acc = x_valid && !cfg_load && !rst;
        m_hit = 1'b0;
        if (m_acc) begin
            w = mq;
            w.push_back(x);
            if (w.size() >= m_len) begin
                m_hit = 1'b1;
                for (int i = 0; i < m_len; i++) begin
                    if (w[w.size()-1-i] != m_pat[i]) m_hit = 1'b0;
                end
            end
        end
        if (m_valid) begin
            chk("model_z", 32'(z), 32'(m_hit));
            chk("model_cfg_err", 32'(cfg_err), 32'(m_err));
            chk("model_match_cnt", 32'(match_cnt), 32'(m_cnt));
        end
        if (rst) begin
            mq.delete();
            m_pat   = 8'b0000_0110;
            m_len   = 4;
            m_ovl   = 1'b1;
            m_err   = 1'b0;
            m_cnt   = 0;
            m_valid = 1'b1;
        end else begin
            m_err = cfg_load && (cfg_len == 0 || cfg_len > MAX_LEN);
            if (cfg_load && !m_err) begin
                m_pat = cfg_pattern;
                m_len = int'(cfg_len);
                m_ovl = cfg_overlap;
                mq.delete();
            end
            if (m_acc) begin
                mq.push_back(x);
                if (mq.size() > MAX_LEN) void'(mq.pop_front());
                if (m_hit && !m_ovl) mq.delete();
            end
            if (CNT_EN) begin
                if (cnt_clr) m_cnt = 0;
                else if (m_hit && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
            end
        end
    end

    task automatic step(input logic b, input logic v, output logic zs);
        x       = b;
        x_valid = v;
        @(negedge clk);
        zs = z;
        @(posedge clk);
        #1;
        x       = 1'b0;
        x_valid = 1'b0;
    endtask

    task automatic send(input logic [15:0] bits, input int n, output logic [15:0] zv);
        logic zs;
        zv = '0;
        for (int i = 0; i < n; i++) begin
            step(bits[n-1-i], 1'b1, zs);
            zv = {zv[14:0], zs};
        end
    endtask

    task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
        logic zs;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        cfg_load    = 1'b1;
        step(1'b0, 1'b0, zs);
        cfg_load    = 1'b0;
    endtask

    initial begin
        logic        zs, a, b, c, d, e;
        logic [15:0] zv;
        rst = 1'b1; x = 1'b0; x_valid = 1'b0; cfg_load = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; cnt_clr = 1'b0;

        // Reset defaults; z held low during reset
        step(1'b0, 1'b1, zs);
        step(1'b0, 1'b1, zs);
        chk("rst_z", 32'(zs), 32'd0);
        rst = 1'b0;
        chk("rst_cfg_err", 32'(cfg_err), 32'd0);
        chk("rst_cnt", 32'(match_cnt), 32'd0);

        // Default 0110 overlapping
        send(16'b0110110, 7, zv);
        chk("ovl_z", 32'(zv), 32'b0001001);
        chk("ovl_cnt", 32'(match_cnt), 32'(cnt_exp(2)));
        cnt_clr = 1'b1; step(1'b0, 1'b0, zs); cnt_clr = 1'b0;
        chk("clr_cnt", 32'(match_cnt), 32'd0);

        // Non-overlapping
        load(8'b0110, 4'd4, 1'b0);
        send(16'b0110110, 7, zv);
        chk("novl_z", 32'(zv), 32'b0001000);
        chk("novl_cnt", 32'(match_cnt), 32'(cnt_exp(1)));

        // Rejected load
        load(8'hFF, 4'd9, 1'b1);
        chk("err_hi", 32'(cfg_err), 32'd1);
        step(1'b0, 1'b0, zs);
        chk("err_lo", 32'(cfg_err), 32'd0);
        send(16'b0110, 4, zv);
        chk("err_keep_z", 32'(zv), 32'b0001);

        // Valid gaps between bits
        step(1'b0, 1'b1, a); step(1'b0, 1'b0, zs); step(1'b1, 1'b1, b);
        step(1'b0, 1'b0, zs); step(1'b0, 1'b0, zs); step(1'b1, 1'b1, c);
        step(1'b0, 1'b0, zs); step(1'b0, 1'b1, d);
        chk("gap_z", 32'({a, b, c, d}), 32'b0001);

        // Bit coinciding with a (rejected) load is dropped
        step(1'b0, 1'b1, a); step(1'b1, 1'b1, b);
        cfg_pattern = '0; cfg_len = 4'd0; cfg_load = 1'b1;
        step(1'b1, 1'b1, c);
        cfg_load = 1'b0;
        chk("drop_z", 32'(c), 32'd0);
        chk("drop_err", 32'(cfg_err), 32'd1);
        step(1'b1, 1'b1, d); step(1'b0, 1'b1, e);
        chk("drop_seq", 32'({a, b, d, e}), 32'b0001);

        // Reset mid-sequence
        send(16'b011, 3, zv);
        rst = 1'b1; step(1'b0, 1'b1, zs); rst = 1'b0;
        chk("rst_mid_z", 32'(zs), 32'd0);
        step(1'b0, 1'b1, zs);
        chk("after_rst_z", 32'(zs), 32'd0);
        send(16'b0110, 4, zv);
        chk("fresh_z", 32'(zv), 32'b0001);

        // Upper pattern bits ignored, then len=1
        load(8'b1111_1101, 4'd2, 1'b1);
        send(16'b01101, 5, zv);
        chk("len2_z", 32'(zv), 32'b01001);
        load(8'h01, 4'd1, 1'b1);
        send(16'b1011, 4, zv);
        chk("len1_z", 32'(zv), 32'b1011);

        // Counter saturation and clear-vs-match priority
        cnt_clr = 1'b1; step(1'b0, 1'b0, zs); cnt_clr = 1'b0;
        send(16'b11111, 5, zv);
        chk("sat_z", 32'(zv), 32'b11111);
        chk("sat_cnt", 32'(match_cnt), 32'(cnt_exp(5)));
        cnt_clr = 1'b1; step(1'b1, 1'b1, zs); cnt_clr = 1'b0;
        chk("clr_hit_z", 32'(zs), 32'd1);
        chk("clr_hit_cnt", 32'(match_cnt), 32'd0);

        // Full-length pattern, non-overlapping
        load(8'b1011_0011, 4'd8, 1'b0);
        send(16'b1011_0011, 8, zv);
        chk("len8_z1", 32'(zv), 32'b0000_0001);
        send(16'b1011_0011, 8, zv);
        chk("len8_z2", 32'(zv), 32'b0000_0001);

        step(1'b0, 1'b0, zs);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
